twi_frame_scheduler: RTL and testbench

- Queues 18-bit TWI frames from the bus sniffer in a small FIFO.
- Sequences the frame presenter one frame at a time, using the presenter's new_data_ready / TX_available handshake.
- Holds the issued frame stable for the whole three-byte UART send.
- Counts frames dropped on overflow, so bursts of bus traffic faster than the UART never corrupt a frame in flight.

---
 rtl/twi_frame_scheduler_if.sv | 24 ++
 rtl/twi_frame_scheduler.sv | 103 ++++++++++
 tb/tb_twi_frame_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/twi_frame_scheduler_if.sv
// rtl/twi_frame_scheduler_if.sv - sniffer/presenter handshake bundle for the TWI frame scheduler
interface twi_frame_scheduler_if;
    logic [17:0] frame_in;
    logic        frame_valid;
    logic [17:0] frame_out;
    logic        new_data_ready;
    logic        TX_available;

    modport master (
        input  frame_in,
        input  frame_valid,
        input  TX_available,
        output frame_out,
        output new_data_ready
    );

    modport slave (
        output frame_in,
        output frame_valid,
        output TX_available,
        input  frame_out,
        input  new_data_ready
    );
endinterface

// File: rtl/twi_frame_scheduler.sv
// rtl/twi_frame_scheduler.sv - FIFO-buffered TWI frame sequencer for the UART frame presenter
// Frames are queued on strobe and issued one at a time; overflow drops are counted.
module twi_frame_scheduler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear_stats,
    twi_frame_scheduler_if.master    bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [CNT_W-1:0]         overflow_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [17:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [17:0]       frame_q;
    logic [CNT_W-1:0]  ovf_q;

    logic full, empty, pop, push, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (!empty && bus.TX_available) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.TX_available) state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.TX_available) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    assign push = bus.frame_valid && (!full || pop);
    assign drop = bus.frame_valid && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            frame_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                frame_q  <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (clear_stats) begin
                ovf_q <= '0;
            end else if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.frame_in;
    end

    assign bus.frame_out      = frame_q;
    assign bus.new_data_ready = (state_q == ISSUE);
    assign fifo_count         = count_q;
    assign fifo_full          = full;
    assign fifo_empty         = empty;
    assign overflow_count     = ovf_q;
endmodule

// File: tb/tb_twi_frame_scheduler.sv
// tb/tb_twi_frame_scheduler.sv - directed scoreboard bench for twi_frame_scheduler
module tb_twi_frame_scheduler;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clear_stats;
    logic [2:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] overflow_count;

    twi_frame_scheduler_if bus ();

    twi_frame_scheduler #(.DEPTH(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .clear_stats    (clear_stats),
        .bus            (bus.master),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .overflow_count (overflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] exp_q[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [17:0] f, input bit expect_accept);
        bus.frame_in    = f;
        bus.frame_valid = 1'b1;
        if (expect_accept) exp_q.push_back(f);
        step();
        bus.frame_valid = 1'b0;
    endtask

    // Presenter model: waits for the request, checks the frame, accepts, finishes.
    task automatic serve(input string tag);
        int          n;
        logic [17:0] e;
        n = 0;
        while (bus.new_data_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " request"}, bus.new_data_ready, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3DEAD;
        chk({tag, " frame"}, bus.frame_out, e);
        step();
        chk({tag, " request held"}, bus.new_data_ready, 1);
        bus.TX_available = 1'b0;
        step();
        chk({tag, " request dropped"}, bus.new_data_ready, 0);
        chk({tag, " frame stable"}, bus.frame_out, e);
        bus.TX_available = 1'b1;
        step();
    endtask

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b1;
        clear_stats      = 1'b0;
        bus.frame_in     = '0;
        bus.frame_valid  = 1'b0;
        bus.TX_available = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("reset frame_out", bus.frame_out, 0);
        chk("reset ndr", bus.new_data_ready, 0);
        chk("reset count", fifo_count, 0);
        chk("reset empty", fifo_empty, 1);
        chk("reset full", fifo_full, 0);
        chk("reset ovf", overflow_count, 0);

        // Single frame latency
        strobe(18'h2A5C3, 1'b1);
        chk("single count after strobe", fifo_count, 1);
        chk("single ndr after strobe", bus.new_data_ready, 0);
        step();
        chk("single ndr issue", bus.new_data_ready, 1);
        chk("single frame_out", bus.frame_out, 18'h2A5C3);
        chk("single count drained", fifo_count, 0);
        serve("single");
        chk("single queue empty", exp_q.size(), 0);

        // Burst of four with presenter busy, then overflow
        bus.TX_available = 1'b0;
        strobe(18'h00001, 1'b1);
        strobe(18'h3FFFF, 1'b1);
        strobe(18'h15555, 1'b1);
        strobe(18'h2AAAA, 1'b1);
        chk("burst full", fifo_full, 1);
        chk("burst count", fifo_count, 4);
        strobe(18'h12345, 1'b0);
        chk("overflow count stays", fifo_count, 4);
        chk("overflow ovf", overflow_count, 1);
        chk("overflow frame_out held", bus.frame_out, 18'h2A5C3);
        bus.TX_available = 1'b1;
        for (int i = 0; i < 4; i++) serve("burst");
        chk("burst drained empty", fifo_empty, 1);

        // Full FIFO with a strobe on the same edge as a pop
        bus.TX_available = 1'b0;
        strobe(18'h01111, 1'b1);
        strobe(18'h02222, 1'b1);
        strobe(18'h03333, 1'b1);
        strobe(18'h04444, 1'b1);
        bus.TX_available = 1'b1;
        strobe(18'h05555, 1'b1);
        chk("pushpop count", fifo_count, 4);
        chk("pushpop ovf", overflow_count, 1);
        chk("pushpop ndr", bus.new_data_ready, 1);
        for (int i = 0; i < 5; i++) serve("pushpop");
        chk("pushpop empty", fifo_empty, 1);

        // Counter saturation and clear priority
        bus.TX_available = 1'b0;
        strobe(18'h0A0A0, 1'b1);
        strobe(18'h0B0B0, 1'b1);
        strobe(18'h0C0C0, 1'b1);
        strobe(18'h0D0D0, 1'b1);
        for (int i = 0; i < 300; i++) strobe(18'h3C3C3, 1'b0);
        chk("sat ovf", overflow_count, 8'hFF);
        chk("sat count", fifo_count, 4);
        clear_stats = 1'b1;
        strobe(18'h3C3C3, 1'b0);
        clear_stats = 1'b0;
        chk("clear priority", overflow_count, 0);
        strobe(18'h3C3C3, 1'b0);
        chk("ovf after clear", overflow_count, 1);
        bus.TX_available = 1'b1;
        for (int i = 0; i < 4; i++) serve("sat");

        // Enable held low
        enable = 1'b0;
        strobe(18'h1E1E1, 1'b1);
        strobe(18'h2D2D2, 1'b1);
        step();
        step();
        step();
        chk("disabled ndr", bus.new_data_ready, 0);
        chk("disabled count", fifo_count, 2);
        enable = 1'b1;
        step();
        chk("enable issues next edge", bus.new_data_ready, 1);
        for (int i = 0; i < 2; i++) serve("enable");

        // Asynchronous reset during WAIT_DONE with frames queued
        bus.TX_available = 1'b0;
        strobe(18'h11111, 1'b1);
        strobe(18'h22222, 1'b1);
        strobe(18'h33333, 1'b1);
        bus.TX_available = 1'b1;
        step();
        chk("rst pre ndr", bus.new_data_ready, 1);
        chk("rst pre frame", bus.frame_out, exp_q.pop_front());
        bus.TX_available = 1'b0;
        step();
        chk("rst pre count", fifo_count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async frame_out", bus.frame_out, 0);
        chk("rst async ndr", bus.new_data_ready, 0);
        chk("rst async empty", fifo_empty, 1);
        chk("rst async count", fifo_count, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.TX_available = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post rst no request", bus.new_data_ready, 0);
        end
        strobe(18'h2F00D, 1'b1);
        serve("post rst");
        chk("final empty", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
